// File: rtl/ofs_plat_ccip_c1_wr_arb_if.sv
// Requester, CCI-P c1 TX/RX and error signals of the c1 write arbiter.
// The arbiter uses the master view; the surrounding system uses slave.
interface ofs_plat_ccip_c1_wr_arb_if #(
  parameter int N_REQ       = 2,
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512,
  parameter int MDATA_WIDTH = 16
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RM_W = MDATA_WIDTH - ID_W;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*2-1:0]          req_len;
  logic [N_REQ*RM_W-1:0]       req_mdata;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;

  logic                        c1_valid;
  logic [ADDR_WIDTH-1:0]       c1_addr;
  logic [1:0]                  c1_len;
  logic                        c1_sop;
  logic [MDATA_WIDTH-1:0]      c1_mdata;
  logic [DATA_WIDTH-1:0]       c1_data;
  logic                        c1_almfull;

  logic                        rsp_valid;
  logic [MDATA_WIDTH-1:0]      rsp_mdata;
  logic [N_REQ-1:0]            req_rsp_valid;
  logic [RM_W-1:0]             req_rsp_mdata;

  logic                        err;

  modport master (
    input  req_valid, req_addr, req_len,
    input  req_mdata, req_data,
    input  c1_almfull, rsp_valid, rsp_mdata,
    output req_ready,
    output c1_valid, c1_addr, c1_len,
    output c1_sop, c1_mdata, c1_data,
    output req_rsp_valid, req_rsp_mdata,
    output err
  );

  modport slave (
    output req_valid, req_addr, req_len,
    output req_mdata, req_data,
    output c1_almfull, rsp_valid, rsp_mdata,
    input  req_ready,
    input  c1_valid, c1_addr, c1_len,
    input  c1_sop, c1_mdata, c1_data,
    input  req_rsp_valid, req_rsp_mdata,
    input  err
  );
endinterface

// File: rtl/ofs_plat_ccip_c1_wr_arb.sv
// Round-robin CCI-P c1 write arbiter with atomic multi-line packets.
// OFS_PLAT_CCIP_WR_ARB_CHECK_EN enables the sticky protocol error check.
module ofs_plat_ccip_c1_wr_arb #(
  parameter int N_REQ       = 2,
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512,
  parameter int MDATA_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  ofs_plat_ccip_c1_wr_arb_if.master bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RM_W = MDATA_WIDTH - ID_W;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  function automatic logic [ID_W-1:0] next_id(
    input logic [ID_W-1:0] id
  );
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] wrap_add(
    input logic [ID_W-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  state_t                 state_q, state_d;
  logic                   almfull_q, almfull_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [1:0]             beat_cnt_q, beat_cnt_d;
  logic [1:0]             len_q, len_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [MDATA_WIDTH-1:0] mdata_q, mdata_d;

  logic                   c1_valid_q, c1_valid_d;
  logic                   c1_sop_q, c1_sop_d;
  logic [ADDR_WIDTH-1:0]  c1_addr_q, c1_addr_d;
  logic [1:0]             c1_len_q, c1_len_d;
  logic [MDATA_WIDTH-1:0] c1_mdata_q, c1_mdata_d;
  logic [DATA_WIDTH-1:0]  c1_data_q, c1_data_d;

  logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [RM_W-1:0]        rsp_mdata_q, rsp_mdata_d;
  logic                   err_q, err_d;

  logic [ID_W-1:0]        pick;
  logic                   pick_vld;
  logic [ID_W-1:0]        cand;
  logic [ID_W-1:0]        sel;
  logic [N_REQ-1:0]       ready;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  in_addr;
  logic [1:0]             in_len;
  logic [RM_W-1:0]        in_mdata;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_id_ok;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = wrap_add(rr_q, i);
      if (bus.req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign sel = (state_q == BURST) ? grant_q : pick;

  // Ready goes only to the packet owner, never under almost-full or reset.
  always_comb begin
    ready = '0;
    if (reset_n && !almfull_q) begin
      if (state_q == BURST) ready[grant_q] = 1'b1;
      else if (pick_vld)    ready[pick]    = 1'b1;
    end
  end

  assign accept   = |(bus.req_valid & ready);
  assign in_addr  = bus.req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign in_len   = bus.req_len[int'(sel)*2 +: 2];
  assign in_mdata = bus.req_mdata[int'(sel)*RM_W +: RM_W];
  assign in_data  = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  // Packet FSM: sop beat latches the header, later beats reuse it.
  always_comb begin
    state_d    = state_q;
    almfull_d  = bus.c1_almfull;
    rr_d       = rr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    mdata_d    = mdata_q;
    c1_valid_d = accept;
    c1_sop_d   = 1'b0;
    c1_addr_d  = c1_addr_q;
    c1_len_d   = c1_len_q;
    c1_mdata_d = c1_mdata_q;
    c1_data_d  = c1_data_q;
    if (accept) begin
      c1_data_d = in_data;
      if (state_q == IDLE) begin
        grant_d    = sel;
        addr_d     = in_addr;
        len_d      = in_len;
        mdata_d    = {sel, in_mdata};
        c1_sop_d   = 1'b1;
        c1_addr_d  = in_addr;
        c1_len_d   = in_len;
        c1_mdata_d = {sel, in_mdata};
        if (in_len == 2'd0) begin
          rr_d = next_id(sel);
        end else begin
          state_d    = BURST;
          beat_cnt_d = 2'd1;
        end
      end else begin
        c1_addr_d  = {addr_q[ADDR_WIDTH-1:2],
                      addr_q[1:0] | beat_cnt_q};
        c1_len_d   = len_q;
        c1_mdata_d = mdata_q;
        if (beat_cnt_q == len_q) begin
          state_d    = IDLE;
          rr_d       = next_id(grant_q);
          beat_cnt_d = 2'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 2'd1;
        end
      end
    end
  end

  assign rsp_id    = bus.rsp_mdata[MDATA_WIDTH-1 -: ID_W];
  assign rsp_id_ok = int'(rsp_id) < N_REQ;

  // Route each write response to the requester named in its mdata.
  always_comb begin
    rsp_valid_d = '0;
    if (bus.rsp_valid && rsp_id_ok) rsp_valid_d[rsp_id] = 1'b1;
    rsp_mdata_d = bus.rsp_mdata[RM_W-1:0];
  end

`ifdef OFS_PLAT_CCIP_WR_ARB_CHECK_EN
  logic sop_bad;

  // Illegal cl_len or misaligned multi-line address on a sop beat.
  always_comb begin
    sop_bad = 1'b0;
    unique case (1'b1)
      in_len == 2'd2: sop_bad = 1'b1;
      in_len == 2'd1: sop_bad = in_addr[0];
      in_len == 2'd3: sop_bad = |in_addr[1:0];
      default:        sop_bad = 1'b0;
    endcase
  end

  assign err_d = err_q
               | (accept && state_q == IDLE && sop_bad)
               | (bus.rsp_valid && !rsp_id_ok);
`else
  assign err_d = 1'b0;
`endif

  // All state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      almfull_q   <= 1'b1;
      rr_q        <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      mdata_q     <= '0;
      c1_valid_q  <= 1'b0;
      c1_sop_q    <= 1'b0;
      c1_addr_q   <= '0;
      c1_len_q    <= '0;
      c1_mdata_q  <= '0;
      c1_data_q   <= '0;
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      almfull_q   <= almfull_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      mdata_q     <= mdata_d;
      c1_valid_q  <= c1_valid_d;
      c1_sop_q    <= c1_sop_d;
      c1_addr_q   <= c1_addr_d;
      c1_len_q    <= c1_len_d;
      c1_mdata_q  <= c1_mdata_d;
      c1_data_q   <= c1_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mdata_q <= rsp_mdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.c1_valid      = c1_valid_q;
  assign bus.c1_sop        = c1_sop_q;
  assign bus.c1_addr       = c1_addr_q;
  assign bus.c1_len        = c1_len_q;
  assign bus.c1_mdata      = c1_mdata_q;
  assign bus.c1_data       = c1_data_q;
  assign bus.req_rsp_valid = rsp_valid_q;
  assign bus.req_rsp_mdata = rsp_mdata_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_ofs_plat_ccip_c1_wr_arb.sv
// Scoreboard bench for the c1 write arbiter.
// Packet-level reference model; monitor checks registered outputs.
module tb_ofs_plat_ccip_c1_wr_arb;
  localparam int N  = 2;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MW = 16;
  localparam int IW = 1;
  localparam int RW = MW - IW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ofs_plat_ccip_c1_wr_arb_if #(
    .N_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MDATA_WIDTH(MW)
  ) bus ();

  ofs_plat_ccip_c1_wr_arb #(
    .N_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MDATA_WIDTH(MW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [1:0]      len;
    logic [RW-1:0]   tag;
    logic [4*DW-1:0] data;
  } pkt_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic          sop;
    logic [MW-1:0] mdata;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  typedef struct {
    logic [N-1:0]  v;
    logic [RW-1:0] m;
    logic          err;
    int            cyc;
  } rsp_t;

  pkt_t  pq[N][$];
  int    bidx[N];
  beat_t eq[$];
  rsp_t  rq[$];
  int    owner = -1;
  int    rr = 0;
  logic  af_prev = 1'b1;
  logic  err_m = 1'b0;
  int    cyc = 0;
  int    stale = 0;
  int    errors = 0;
  int    checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic bad(input pkt_t p);
    return (p.len == 2'd2) ||
           (p.len == 2'd1 && p.addr[0]) ||
           (p.len == 2'd3 && p.addr[1:0] != 2'd0);
  endfunction

  function automatic pkt_t mk(input logic [AW-1:0] a,
                              input logic [1:0] l);
    pkt_t p;
    p.addr = a;
    p.len  = l;
    p.tag  = RW'($urandom);
    for (int w = 0; w < 4*DW/32; w++)
      p.data[w*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    logic [AW-1:0] a;
    logic [1:0]    l;
    int            k;
    k = $urandom_range(0, 2);
    l = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd3;
    a = AW'({$urandom, $urandom});
    a[1:0] = a[1:0] & ~l;
    return mk(a, l);
  endfunction

  // One clock of stimulus plus the model's view of that cycle.
  task automatic step(input logic af, input logic rst,
                      input logic rv, input logic [MW-1:0] rm,
                      input int gap);
    logic [N-1:0]  v, acc, exp_acc;
    logic [IW-1:0] rid;
    pkt_t          p;
    beat_t         b;
    rsp_t          r;
    @(posedge clk);
    #1;
    reset_n        = !rst;
    bus.c1_almfull = af;
    bus.rsp_valid  = rv;
    bus.rsp_mdata  = rm;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        p = pq[i][0];
        v[i] = (gap == 0) || ($urandom_range(0, 99) >= gap);
        bus.req_addr[i*AW +: AW]   = p.addr;
        bus.req_len[i*2 +: 2]      = p.len;
        bus.req_mdata[i*RW +: RW]  = p.tag;
        bus.req_data[i*DW +: DW]   = p.data[bidx[i]*DW +: DW];
      end
    end
    bus.req_valid = v;
    #1;
    acc = v & bus.req_ready;
    exp_acc = '0;
    if (!rst && !af_prev) begin
      if (owner >= 0) exp_acc[owner] = v[owner];
      else
        for (int k = 0; k < N; k++)
          if (exp_acc == '0 && v[(rr+k)%N])
            exp_acc[(rr+k)%N] = 1'b1;
    end
    chk("grant", acc, exp_acc);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        p = pq[i][0];
        b.addr  = p.addr | AW'(bidx[i]);
        b.len   = p.len;
        b.sop   = (bidx[i] == 0);
        b.mdata = {IW'(i), p.tag};
        b.data  = p.data[bidx[i]*DW +: DW];
        b.cyc   = cyc;
        eq.push_back(b);
        if (bidx[i] == 0 && bad(p)) err_m = 1'b1;
        if (bidx[i] == int'(p.len)) begin
          void'(pq[i].pop_front());
          bidx[i] = 0;
          owner = -1;
          rr = (i + 1) % N;
        end else begin
          bidx[i]++;
          owner = i;
        end
      end
    end
    rid = rm[MW-1 -: IW];
    r.v = '0;
    r.m = rm[RW-1:0];
    r.cyc = cyc;
    if (rst) begin
      for (int i = 0; i < N; i++)
        if (bidx[i] > 0) begin
          void'(pq[i].pop_front());
          bidx[i] = 0;
        end
      owner = -1;
      rr = 0;
      err_m = 1'b0;
    end else if (rv) begin
      if (int'(rid) < N) r.v[rid] = 1'b1;
      else err_m = 1'b1;
    end
`ifdef OFS_PLAT_CCIP_WR_ARB_CHECK_EN
    r.err = err_m;
`else
    r.err = 1'b0;
`endif
    rq.push_back(r);
    af_prev = rst ? 1'b1 : af;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic drain(input int gap, input int afpct);
    int n = 0;
    while (pending() > 0 && n < 300) begin
      step(afpct > 0 && $urandom_range(0, 99) < afpct,
           1'b0, 1'b0, '0, gap);
      n++;
    end
    chk("drain_timeout", n >= 300, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 0);
  endtask

  // Monitor: compares registered outputs against queued expectations.
  always @(negedge clk) begin : mon
    beat_t b;
    rsp_t  r;
    if (rq.size() > 0 && rq[0].cyc == cyc - 1) begin
      r = rq.pop_front();
      chk("rsp_valid", bus.req_rsp_valid, r.v);
      if (r.v != '0) chk("rsp_mdata", bus.req_rsp_mdata, r.m);
      chk("err", bus.err, r.err);
    end
    while (eq.size() > 0 && eq[0].cyc < cyc - 1) begin
      void'(eq.pop_front());
      stale++;
    end
    if (eq.size() > 0 && eq[0].cyc == cyc - 1) begin
      b = eq.pop_front();
      chk("c1_valid", bus.c1_valid, 1);
      if (bus.c1_valid) begin
        chk("c1_addr", bus.c1_addr, b.addr);
        chk("c1_sop", bus.c1_sop, b.sop);
        chk("c1_len", bus.c1_len, b.len);
        chk("c1_mdata", bus.c1_mdata, b.mdata);
        chk("c1_data", bus.c1_data, b.data);
      end
    end else begin
      chk("c1_idle", bus.c1_valid, 0);
    end
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.req_mdata  = '0;
    bus.req_data   = '0;
    bus.c1_almfull = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_mdata  = '0;
    for (int i = 0; i < N; i++) bidx[i] = 0;

    repeat (3) step(1'b0, 1'b1, 1'b0, '0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, 0);

    // single 4-line packet
    pq[0].push_back(mk(42'h100, 2'd3));
    drain(0, 0);

    // two 2-line packets competing
    pq[0].push_back(mk(42'h200, 2'd1));
    pq[1].push_back(mk(42'h300, 2'd1));
    drain(0, 0);
    pq[0].push_back(mk(42'h240, 2'd0));
    pq[1].push_back(mk(42'h340, 2'd0));
    drain(0, 0);

    // almost-full pause mid-packet with a competitor waiting
    pq[0].push_back(mk(42'h400, 2'd3));
    pq[1].push_back(mk(42'h500, 2'd0));
    for (int n = 0; n < 20 && bidx[0] < 2; n++)
      step(1'b0, 1'b0, 1'b0, '0, 0);
    repeat (5) step(1'b1, 1'b0, 1'b0, '0, 0);
    drain(0, 0);

    // response routing
    step(1'b0, 1'b0, 1'b1, 16'h8005, 0);
    step(1'b0, 1'b0, 1'b1, 16'h0003, 0);
    step(1'b0, 1'b0, 1'b0, '0, 0);

    // reset in the middle of a packet
    pq[0].push_back(mk(42'h600, 2'd3));
    pq[1].push_back(mk(42'h680, 2'd1));
    for (int n = 0; n < 20 && bidx[0] < 2; n++)
      step(1'b0, 1'b0, 1'b0, '0, 0);
    step(1'b0, 1'b1, 1'b0, '0, 0);
    pq[0].push_back(mk(42'h700, 2'd0));
    drain(0, 0);

    // misaligned 2-line packet
    pq[0].push_back(mk(42'h101, 2'd1));
    drain(0, 0);
    step(1'b0, 1'b1, 1'b0, '0, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, 0);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 2 && $urandom_range(0, 3) == 0)
          pq[i].push_back(rnd_pkt());
      step($urandom_range(0, 99) < 15, 1'b0,
           $urandom_range(0, 99) < 30, MW'($urandom), 25);
    end
    drain(25, 10);

    chk("leftover", eq.size() + stale, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
